// File: rtl/decoder_n_seq.sv
// decoder_n_seq: registered binary-to-one-hot decoder with valid/ready
// handshakes and a SCAN mode that strobes each line for DWELL cycles.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   mode             0 = DIRECT decode, 1 = SCAN walk
//   en               DIRECT: gates acceptance; SCAN: freezes the walk
//   in_valid/ready   input handshake, in_code = binary code
//   out_valid/ready  output handshake, out = one-hot word
//   scan_idx         binary index of the active line
//   scan_wrap        one-cycle pulse when the SCAN index wraps to 0
module decoder_n_seq #(
   parameter int IN_W  = 2,
   parameter int DWELL = 4,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mode,
   input  logic                  en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_W-1:0]       in_code,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [(1<<IN_W)-1:0]  out,
   output logic [IN_W-1:0]       scan_idx,
   output logic                  scan_wrap
);

   localparam int OUT_W = 1 << IN_W;

   localparam logic [OUT_W-1:0] ONE      = OUT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [IN_W-1:0]  IDX_LAST = IN_W'(OUT_W - 1);

   typedef enum logic [1:0] {
      ST_DIRECT,
      ST_SCAN,
      ST_DRAIN
   } state_e;

   state_e            state_q, state_d;
   logic [OUT_W-1:0]  out_q, out_d;
   logic              ov_q, ov_d;
   logic [IN_W-1:0]   idx_q, idx_d;
   logic              wrap_q, wrap_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IN_W-1:0]   idx_inc;

   assign idx_inc = idx_q + IN_W'(1);

   // rst_n term keeps in_ready low while the block is held in reset.
   assign in_ready = rst_n & en & ~mode
                   & (state_q == ST_DIRECT)
                   & (~ov_q | out_ready);

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      ov_d    = ov_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;

      unique case (state_q)
         ST_DIRECT: begin
            if (mode) begin
               if (ov_q) begin
                  state_d = ST_DRAIN;
                  // Word taken this very cycle: nothing left to hold.
                  if (out_ready) begin
                     ov_d  = 1'b0;
                     out_d = '0;
                  end
               end else begin
                  state_d = ST_SCAN;
                  idx_d   = '0;
                  out_d   = ONE;
                  ov_d    = 1'b1;
                  cnt_d   = '0;
               end
            end else if (in_valid && in_ready) begin
               out_d = ONE << in_code;
               idx_d = in_code;
               ov_d  = 1'b1;
            end else if (ov_q && out_ready) begin
               out_d = '0;
               ov_d  = 1'b0;
            end
         end

         ST_DRAIN: begin
            if (!mode) begin
               state_d = ST_DIRECT;
               if (ov_q && out_ready) begin
                  out_d = '0;
                  ov_d  = 1'b0;
               end
            end else if (!ov_q || out_ready) begin
               state_d = ST_SCAN;
               idx_d   = '0;
               out_d   = ONE;
               ov_d    = 1'b1;
               cnt_d   = '0;
            end
         end

         ST_SCAN: begin
            if (!mode) begin
               state_d = ST_DIRECT;
               out_d   = '0;
               ov_d    = 1'b0;
               cnt_d   = '0;
            end else if (en) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d  = '0;
                  idx_d  = idx_inc;
                  out_d  = ONE << idx_inc;
                  wrap_d = (idx_q == IDX_LAST);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_DIRECT;
            out_d   = '0;
            ov_d    = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_DIRECT;
         out_q   <= '0;
         ov_q    <= 1'b0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         ov_q    <= ov_d;
         idx_q   <= idx_d;
         wrap_q  <= wrap_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out       = out_q;
   assign out_valid = ov_q;
   assign scan_idx  = idx_q;
   assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_decoder_n_seq.sv
// tb_decoder_n_seq: directed checks of decoder_n_seq, table-driven
// DIRECT vectors plus hand-written stall, SCAN, DRAIN and reset cases.
module tb_decoder_n_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic mode = 1'b0;
   logic en = 1'b0;
   logic iv = 1'b0;
   logic ordy = 1'b0;

   logic [1:0] code2 = '0;
   logic       ir2, ov2, wr2;
   logic [3:0] out2;
   logic [1:0] idx2;

   logic [2:0] code3 = '0;
   logic       ir3, ov3, wr3;
   logic [7:0] out3;
   logic [2:0] idx3;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   decoder_n_seq #(.IN_W(2), .DWELL(3), .CNT_W(8)) u2 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .en(en),
      .in_valid(iv), .in_ready(ir2), .in_code(code2),
      .out_valid(ov2), .out_ready(ordy), .out(out2),
      .scan_idx(idx2), .scan_wrap(wr2)
   );

   decoder_n_seq #(.IN_W(3), .DWELL(4), .CNT_W(8)) u3 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .en(en),
      .in_valid(iv), .in_ready(ir3), .in_code(code3),
      .out_valid(ov3), .out_ready(ordy), .out(out3),
      .scan_idx(idx3), .scan_wrap(wr3)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       m, e, v, r;
      logic [1:0] c;
      logic       x_rdy;
      logic [3:0] x_out;
      logic       x_ov;
      logic [1:0] x_idx;
   } vec_t;

   vec_t tbl[9];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      // m e v r c  rdy out  ov idx
      tbl[0] = '{0,1,1,1,2'd0, 1,4'b0001,1,2'd0};
      tbl[1] = '{0,1,1,1,2'd1, 1,4'b0010,1,2'd1};
      tbl[2] = '{0,1,1,1,2'd2, 1,4'b0100,1,2'd2};
      tbl[3] = '{0,1,1,1,2'd3, 1,4'b1000,1,2'd3};
      tbl[4] = '{0,1,0,1,2'd0, 1,4'b0000,0,2'd3};
      tbl[5] = '{0,0,1,1,2'd1, 0,4'b0000,0,2'd3};
      tbl[6] = '{0,1,1,0,2'd2, 1,4'b0100,1,2'd2};
      tbl[7] = '{0,1,1,0,2'd1, 0,4'b0100,1,2'd2};
      tbl[8] = '{0,1,0,1,2'd0, 1,4'b0000,0,2'd2};

      // reset state
      #2 rst_n = 1'b0;
      mode = 1'b0; en = 1'b1; iv = 1'b1; ordy = 1'b1;
      #1;
      chk("rst_ready", 32'(ir2), 0);
      chk("rst_out", 32'(out2), 0);
      chk("rst_ov", 32'(ov2), 0);
      chk("rst_idx", 32'(idx2), 0);
      chk("rst_wrap", 32'(wr2), 0);
      iv = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // DIRECT table
      for (int i = 0; i < 9; i++) begin
         mode = tbl[i].m; en = tbl[i].e; iv = tbl[i].v;
         ordy = tbl[i].r; code2 = tbl[i].c;
         code3 = {1'b0, tbl[i].c};
         #1;
         chk($sformatf("tbl%0d_ready", i), 32'(ir2), 32'(tbl[i].x_rdy));
         step();
         chk($sformatf("tbl%0d_out", i), 32'(out2), 32'(tbl[i].x_out));
         chk($sformatf("tbl%0d_ov", i), 32'(ov2), 32'(tbl[i].x_ov));
         chk($sformatf("tbl%0d_idx", i), 32'(idx2), 32'(tbl[i].x_idx));
      end

      // IN_W=3 stall: 5 held while out_ready low
      mode = 0; en = 1; iv = 1; ordy = 0; code3 = 3'd5;
      #1;
      chk("st_ready0", 32'(ir3), 1);
      step();
      chk("st_out0", 32'(out3), 32'h20);
      code3 = 3'd2;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("st_ready%0d", i + 1), 32'(ir3), 0);
         step();
         chk($sformatf("st_hold%0d", i + 1), 32'(out3), 32'h20);
         chk($sformatf("st_idx%0d", i + 1), 32'(idx3), 5);
      end
      ordy = 1;
      #1;
      chk("st_ready_go", 32'(ir3), 1);
      step();
      chk("st_out2", 32'(out3), 32'h04);
      chk("st_idx2", 32'(idx3), 2);
      iv = 0;
      step();
      chk("st_clr", 32'(ov3), 0);

      // SCAN walk, DWELL=3
      mode = 1; en = 1; iv = 0;
      step();
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) step();
         chk($sformatf("sc%0d_out", c), 32'(out2),
             32'(1 << ((c / 3) % 4)));
         chk($sformatf("sc%0d_wrap", c), 32'(wr2), 32'(c == 12));
         chk($sformatf("sc%0d_ov", c), 32'(ov2), 1);
      end
      #1;
      chk("sc_ready", 32'(ir2), 0);

      // freeze mid-dwell
      step();
      en = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("fz%0d_out", i), 32'(out2), 32'b0001);
         chk($sformatf("fz%0d_idx", i), 32'(idx2), 0);
      end
      en = 1;
      step();
      chk("fz_res1", 32'(out2), 32'b0001);
      step();
      chk("fz_res2", 32'(out2), 32'b0010);
      chk("fz_res2_idx", 32'(idx2), 1);

      // back to DIRECT
      mode = 0;
      step();
      chk("sd_out", 32'(out2), 0);
      chk("sd_ov", 32'(ov2), 0);
      chk("sd_idx", 32'(idx2), 1);

      // DRAIN
      iv = 1; code2 = 2'd3; code3 = 3'd3; ordy = 0;
      step();
      chk("dr_load", 32'(out2), 32'b1000);
      iv = 0; mode = 1;
      #1;
      chk("dr_ready", 32'(ir2), 0);
      step();
      chk("dr_hold1", 32'(out2), 32'b1000);
      chk("dr_ov1", 32'(ov2), 1);
      step();
      chk("dr_hold2", 32'(out2), 32'b1000);
      ordy = 1;
      step();
      chk("dr_scan", 32'(out2), 32'b0001);
      chk("dr_scan_idx", 32'(idx2), 0);
      chk("dr_scan_ov", 32'(ov2), 1);

      // async reset mid-SCAN at index 2
      for (int i = 0; i < 6; i++) step();
      chk("ar_pre_idx", 32'(idx2), 2);
      #2 rst_n = 0;
      #1;
      chk("ar_out", 32'(out2), 0);
      chk("ar_ov", 32'(ov2), 0);
      chk("ar_idx", 32'(idx2), 0);
      chk("ar_wrap", 32'(wr2), 0);
      chk("ar_ready", 32'(ir2), 0);
      @(negedge clk);
      rst_n = 1;
      mode = 0; en = 1; iv = 1; code2 = 2'd1; ordy = 1;
      step();
      chk("ar_direct", 32'(out2), 32'b0010);
      chk("ar_direct_ov", 32'(ov2), 1);
      iv = 0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decoder_n_seq.md
Name: decoder_n_seq

Overview:
- Parametrised, registered binary-to-one-hot decoder: IN_W-bit code to 2**IN_W one-hot lines, with valid/ready handshakes on both sides.
- Adds a SCAN mode that walks the active output line with a programmable dwell time, for row/column strobing.
- Sits between control logic and select/strobe consumers (mux selects, display/keypad scan lines).

Parameters:
- IN_W, 2, code width; legal range 1..6. OUT_W = 2**IN_W is a derived localparam.
- DWELL, 4, cycles each line stays active in SCAN mode; legal range >=1.
- CNT_W, 8, dwell counter width; DWELL must fit in CNT_W bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = DIRECT, 1 = SCAN; level-sampled every cycle.
- en  in  1  global enable; DIRECT: gates acceptance; SCAN: freezes dwell counter and index.
- in_valid  in  1  in_code valid.
- in_ready  out  1  block can accept in_code.
- in_code  in  IN_W  binary code to decode.
- out_valid  out  1  out holds a valid one-hot word.
- out_ready  in  1  downstream accepts out.
- out  out  OUT_W  one-hot output; all-zero when out_valid=0.
- scan_idx  out  IN_W  binary index of the active line (DIRECT: last decoded code).
- scan_wrap  out  1  one-cycle pulse when SCAN index wraps OUT_W-1 -> 0.

Behaviour:
- Reset (async assert, sync release): state=DIRECT, out=0, out_valid=0, scan_idx=0, scan_wrap=0, dwell counter=0. in_ready is combinational and reads 0 while rst_n=0.
- FSM states: DIRECT, SCAN, DRAIN.
- DIRECT:
  - in_ready = en & mode==0 & (!out_valid | out_ready).
  - Transfer when in_valid & in_ready. Next cycle: out = 1<<in_code, scan_idx = in_code, out_valid=1. Latency 1 cycle.
  - out_valid & out_ready with no new transfer: out_valid->0, out->0 next cycle.
  - Simultaneous drain and transfer: new word loads and out_valid stays 1. Full throughput is 1 word per cycle.
  - Stall (out_valid & !out_ready): out and scan_idx hold stable, in_ready=0.
  - mode=1 while out_valid=1 -> DRAIN. mode=1 while out_valid=0 -> SCAN. Neither case accepts input.
- DRAIN:
  - in_ready=0; holds the pending word until out_valid & out_ready, then goes to SCAN.
  - mode returning to 0 before drain -> DIRECT with the word still held.
- SCAN:
  - Entry cycle: scan_idx=0, out=1, out_valid=1, dwell counter=0.
  - in_ready=0 throughout; out_ready is ignored and out_valid stays 1.
  - With en=1, the counter increments each cycle. At DWELL-1 the counter clears and scan_idx increments, so each line is active exactly DWELL cycles.
  - Index step OUT_W-1 -> 0: scan_wrap=1 for that one cycle (registered, coincident with out=1).
  - en=0 freezes counter, index and out; no wrap pulse.
  - mode=0: next cycle -> DIRECT with out=0, out_valid=0, counter=0. scan_idx holds its last value.
- out is always zero or exactly one bit set; never multi-hot.
- IN_W=1 degenerates to 1-to-2; the SCAN wrap pulse then occurs every 2*DWELL cycles.
- Reset mid-operation: all registers immediately take reset values; any pending word is discarded.

Test Plan:
- IN_W=2, mode=0, en=1, out_ready=1; in_code 0,1,2,3 on back-to-back valid cycles -> out 0001,0010,0100,1000 on cycles 1..4, out_valid held 1, in_ready stays 1.
- IN_W=3; decode 5 with out_ready=0 for 3 cycles -> out=00100000 held, in_ready=0, next in_code 2 not taken until the out_ready cycle, then out=00000100.
- IN_W=2, DWELL=3, mode=1, en=1 -> out sequence 0001x3, 0010x3, 0100x3, 1000x3, 0001. scan_wrap=1 only on the cycle out returns to 0001 (cycle 12 after entry).
- SCAN with en=0 for 5 cycles mid-dwell -> out, scan_idx and counter frozen. Resume completes the remaining dwell count exactly.
- DIRECT word pending with out_ready=0, then mode=1 -> DRAIN holds the word. Raise out_ready -> next cycle SCAN with out=0001.
- Assert rst_n=0 asynchronously mid-SCAN (scan_idx=2) -> out=0, out_valid=0, scan_idx=0, scan_wrap=0 before the next clk edge. After release, state is DIRECT.
